// File: rtl/simple_if_array.sv
// simple_if_array: ROWS x COLS lanes, each with a data reg and a registered inverted result (data_o/result_o packed lane L=r*COLS+c at [L*W +: W]), per-lane wr_en/wr_data, combinational rd_row/rd_col read-back with rd_err; define SIMPLE_IF_ARRAY_CHECK_EN to add the sticky shadow self-check output chk_err
module simple_if_array #(
  parameter int W = 8,
  parameter int ROWS = 2,
  parameter int COLS = 3,
  localparam int N = ROWS * COLS,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  wr_en,
  input  logic [N*W-1:0] wr_data,
  output logic [N*W-1:0] data_o,
  output logic [N*W-1:0] result_o,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  rd_result,
  output logic          rd_err
`ifdef SIMPLE_IF_ARRAY_CHECK_EN
  ,
  output logic          chk_err
`endif
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data_o <= '0;
      result_o <= '0;
    end else begin
      for (int l = 0; l < N; l++)
        if (wr_en[l]) data_o[l*W +: W] <= wr_data[l*W +: W];
      result_o <= ~data_o;
    end
  assign rd_err = ({1'b0, rd_row} >= (RW+1)'(ROWS)) || ({1'b0, rd_col} >= (CW+1)'(COLS));
  always_comb begin
    rd_data = '0;
    rd_result = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (int'(rd_row) == r && int'(rd_col) == c) begin
          rd_data = data_o[(r*COLS+c)*W +: W];
          rd_result = result_o[(r*COLS+c)*W +: W];
        end
  end
`ifdef SIMPLE_IF_ARRAY_CHECK_EN
  logic [N*W-1:0] shadow;
  logic armed;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shadow <= '0;
      armed <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      shadow <= data_o;
      armed <= 1'b1;
      if (armed && result_o != ~shadow) chk_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_simple_if_array.sv
// tb_simple_if_array: randomized and directed checks of simple_if_array (2x3 and 1x1) against a lane-array model
module tb_simple_if_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] wr_en = '0;
  logic [47:0] wr_data = '0;
  logic [47:0] data_o, result_o;
  logic [0:0] rd_row = '0;
  logic [1:0] rd_col = '0;
  logic [7:0] rd_data, rd_result;
  logic rd_err;
  logic [0:0] wr_en1 = 1'b1;
  logic [7:0] wr_data1 = '0;
  logic [7:0] data1, result1, rd_data1, rd_result1;
  logic [0:0] rd_row1 = '0, rd_col1 = '0;
  logic rd_err1;
`ifdef SIMPLE_IF_ARRAY_CHECK_EN
  logic chk_err, chk_err1;
`endif
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  byte unsigned md[6], mr[6];
  byte unsigned m1d, m1r;
  simple_if_array #(.W(8), .ROWS(2), .COLS(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .data_o(data_o), .result_o(result_o), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_result(rd_result), .rd_err(rd_err)
`ifdef SIMPLE_IF_ARRAY_CHECK_EN
    , .chk_err(chk_err)
`endif
  );
  simple_if_array #(.W(8), .ROWS(1), .COLS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .wr_data(wr_data1),
    .data_o(data1), .result_o(result1), .rd_row(rd_row1), .rd_col(rd_col1),
    .rd_data(rd_data1), .rd_result(rd_result1), .rd_err(rd_err1)
`ifdef SIMPLE_IF_ARRAY_CHECK_EN
    , .chk_err(chk_err1)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  task automatic model_reset();
    foreach (md[l]) begin
      md[l] = 0;
      mr[l] = 0;
    end
    m1d = 0;
    m1r = 0;
  endtask
  task automatic check_all();
    bit err;
    int l;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("data[%0d]", i), 64'(data_o[i*8 +: 8]), 64'(md[i]));
      check($sformatf("result[%0d]", i), 64'(result_o[i*8 +: 8]), 64'(mr[i]));
    end
    err = rd_col >= 3;
    l = int'(rd_row) * 3 + int'(rd_col);
    check("rd_err", 64'(rd_err), 64'(err));
    check("rd_data", 64'(rd_data), err ? 64'd0 : 64'(md[l]));
    check("rd_result", 64'(rd_result), err ? 64'd0 : 64'(mr[l]));
    check("data1", 64'(data1), 64'(m1d));
    check("result1", 64'(result1), 64'(m1r));
    check("rd_result1", 64'(rd_result1), 64'(m1r));
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 6; i++) begin
        mr[i] = ~md[i];
        if (wr_en[i]) md[i] = wr_data[i*8 +: 8];
      end
      m1r = ~m1d;
      if (wr_en1[0]) m1d = wr_data1;
    end
    cyc++;
    #1;
    check_all();
  endtask
  initial begin
    byte unsigned off[6] = '{0, 1, 2, 10, 11, 12};
    model_reset();
    wr_en = '1;
    wr_data = {$urandom, $urandom};
    wr_data1 = 8'($urandom);
    repeat (3) tick();
    check("reset_data", 64'(data_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    wr_en = '0;
    wr_en1 = 1'b0;
    rst_n = 1'b1;
    tick();
    check("first_edge_ones", 64'(result_o), 64'hFFFF_FFFF_FFFF);
    check("first_edge_ones1", 64'(result1), 64'hFF);
    wr_en1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wr_en = '1;
      for (int i = 0; i < 6; i++) wr_data[i*8 +: 8] = 8'(k + off[i]);
      wr_data1 = 8'(k + 200);
      rd_row = 1'($urandom_range(1));
      rd_col = 2'($urandom_range(3));
      tick();
    end
    check("wrap_c8", 64'(result1), 64'(8'hFF ^ 8'(18 + 200)));
    for (int k = 0; k < 40; k++) begin
      wr_en = 6'($urandom);
      wr_data = {$urandom, $urandom};
      wr_en1 = 1'($urandom);
      wr_data1 = 8'($urandom);
      rd_row = 1'($urandom_range(1));
      rd_col = 2'($urandom_range(3));
      tick();
    end
    wr_en = 6'b100000;
    wr_data = {8'h5A, 40'h0};
    tick();
    wr_en = '0;
    tick();
    check("sel_5a", 64'(result_o[47:40]), 64'hA5);
    wr_en = 6'b001000;
    wr_data = {16'h0, 8'h0F, 24'h0};
    rd_row = 1'b1;
    rd_col = 2'd0;
    tick();
    wr_en = '0;
    tick();
    check("rb_data", 64'(rd_data), 64'h0F);
    check("rb_result", 64'(rd_result), 64'hF0);
    rd_col = 2'd3;
    #1;
    check("rb_err", 64'(rd_err), 64'd1);
    check("rb_err_zero", 64'({rd_data, rd_result}), 64'd0);
    for (int k = 0; k < 4; k++) begin
      wr_en = '1;
      wr_data = {$urandom, $urandom};
      tick();
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_data", 64'(data_o), 64'd0);
    check("async_result", 64'(result_o), 64'd0);
    check("async_data1", 64'({data1, result1}), 64'd0);
    model_reset();
    wr_en = '1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = '0;
    tick();
    check("post_reset_ones", 64'(result_o), 64'hFFFF_FFFF_FFFF);
    for (int k = 0; k < 10; k++) begin
      wr_en = 6'($urandom);
      wr_data = {$urandom, $urandom};
      rd_row = 1'($urandom_range(1));
      rd_col = 2'($urandom_range(3));
      tick();
    end
`ifdef SIMPLE_IF_ARRAY_CHECK_EN
    check("chk_err", 64'(chk_err), 64'd0);
    check("chk_err1", 64'(chk_err1), 64'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
